adder_arbiter: RTL and testbench

- Shares one 32-bit CarrySelectAdder (ports A, B, Sum, Cout) between NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready request channel per requester and a single registered response channel with backpressure.
- Flags signed overflow per result and keeps a saturating overflow counter.
- Sits between the ALU issue logic and the adder datapath. It is the only driver of the adder inputs.

---
 rtl/adder_arbiter.sv | 173 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin front end that shares one 32-bit carry-select adder between NUM_REQ requesters.
// Each granted operation runs IDLE -> EXEC -> RESP and returns through a single registered response.

module carry_select_adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);
    logic [8:0] carry;

    assign carry[0] = 1'b0;

    // Each 4-bit block precomputes both carry-in cases; the incoming carry only drives the selects.
    for (genvar g = 0; g < 8; g++) begin : g_blk
        logic [4:0] s0;
        logic [4:0] s1;
        assign s0 = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]};
        assign s1 = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]} + 5'd1;
        assign sum_o[4*g +: 4] = carry[g] ? s1[3:0] : s0[3:0];
        assign carry[g+1]      = carry[g] ? s1[4]   : s0[4];
    end

    assign cout_o = carry[8];
endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_a,
    input  logic [32*NUM_REQ-1:0]  req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [31:0]            resp_sum,
    output logic                   resp_cout,
    output logic                   resp_ovf,
    output logic                   busy,
    output logic [15:0]            ovf_count,
    output logic [1:0]             dbg_state_o
);
    // Handshake: a request transfers on a rising edge where req_valid[i] && req_ready[i];
    // a response transfers on a rising edge where resp_valid && resp_ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [31:0]    op_a_q, op_a_d;
    logic [31:0]    op_b_q, op_b_d;
    logic [IDW-1:0] op_id_q, op_id_d;
    logic           resp_valid_q, resp_valid_d;
    logic [IDW-1:0] resp_id_q, resp_id_d;
    logic [31:0]    resp_sum_q, resp_sum_d;
    logic           resp_cout_q, resp_cout_d;
    logic           resp_ovf_q, resp_ovf_d;
    logic [15:0]    ovf_count_q, ovf_count_d;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [31:0]    add_sum;
    logic           add_cout;

    carry_select_adder u_adder (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Search starts just after the last winner so every requester is reached within NUM_REQ grants.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(last_grant_q) + k) % NUM_REQ);
            end
        end
    end

    assign req_ready = (state_q == IDLE && grant_found) ? (NUM_REQ'(1) << grant_idx) : '0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_sum_d   = resp_sum_q;
        resp_cout_d  = resp_cout_q;
        resp_ovf_d   = resp_ovf_q;
        ovf_count_d  = ovf_count_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    op_a_d       = req_a[32*int'(grant_idx) +: 32];
                    op_b_d       = req_b[32*int'(grant_idx) +: 32];
                    op_id_d      = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                resp_sum_d   = add_sum;
                resp_cout_d  = add_cout;
                resp_id_d    = op_id_q;
                resp_ovf_d   = (op_a_q[31] == op_b_q[31]) && (add_sum[31] != op_a_q[31]);
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                    if (resp_ovf_q && ovf_count_q != 16'hFFFF) begin
                        ovf_count_d = ovf_count_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_ovf_q   <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_sum_q   <= resp_sum_d;
            resp_cout_q  <= resp_cout_d;
            resp_ovf_q   <= resp_ovf_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_sum    = resp_sum_q;
    assign resp_cout   = resp_cout_q;
    assign resp_ovf    = resp_ovf_q;
    assign ovf_count   = ovf_count_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: arithmetic corners, round-robin order, backpressure,
// reset during an operation and overflow-counter saturation.

module tb_adder_arbiter;
    localparam int NUM_REQ = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a = '0;
    logic [32*NUM_REQ-1:0] req_b = '0;
    logic                  resp_valid;
    logic                  resp_ready = 1'b0;
    logic [1:0]            resp_id;
    logic [31:0]           resp_sum;
    logic                  resp_cout;
    logic                  resp_ovf;
    logic                  busy;
    logic [15:0]           ovf_count;
    logic [1:0]            dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    adder_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_sum    (resp_sum),
        .resp_cout   (resp_cout),
        .resp_ovf    (resp_ovf),
        .busy        (busy),
        .ovf_count   (ovf_count),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[32*idx +: 32] = a;
        req_b[32*idx +: 32] = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++; if ({resp_id, resp_sum, resp_cout, resp_ovf} !== 36'd0) begin n_err++; $display("FAIL reset_resp got id=%0d sum=%h c=%b o=%b exp all 0", resp_id, resp_sum, resp_cout, resp_ovf); end
        n_cmp++; if (ovf_count !== 16'd0) begin n_err++; $display("FAIL reset_ovf_count got=%h exp=0000", ovf_count); end
        rst = 1'b0;
    endtask

    // One isolated operation: grant, EXEC cycle, response two edges after the grant, accept.
    task automatic test_single_op(input string name, input int idx, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] exp_sum,
                                  input logic exp_cout, input logic exp_ovf, input logic [15:0] exp_cnt);
        logic [3:0] exp_grant;
        logic [1:0] exp_id;
        exp_grant = 4'b0001 << idx;
        exp_id    = idx[1:0];
        @(negedge clk);
        set_req(idx, a, b);
        req_valid  = exp_grant;
        resp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== exp_grant) begin n_err++; $display("FAIL %s_grant got=%b exp=%b", name, req_ready, exp_grant); end
        @(negedge clk);
        req_valid = '0;
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s_exec got valid=%b busy=%b exp valid=0 busy=1", name, resp_valid, busy); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency got valid=%b exp=1", name, resp_valid); end
        n_cmp++; if (resp_sum !== exp_sum) begin n_err++; $display("FAIL %s_sum got=%h exp=%h", name, resp_sum, exp_sum); end
        n_cmp++; if (resp_cout !== exp_cout || resp_ovf !== exp_ovf) begin n_err++; $display("FAIL %s_flags got c=%b o=%b exp c=%b o=%b", name, resp_cout, resp_ovf, exp_cout, exp_ovf); end
        n_cmp++; if (resp_id !== exp_id) begin n_err++; $display("FAIL %s_id got=%0d exp=%0d", name, resp_id, exp_id); end
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL %s_accept got valid=%b busy=%b exp 0 0", name, resp_valid, busy); end
        n_cmp++; if (ovf_count !== exp_cnt) begin n_err++; $display("FAIL %s_ovf_count got=%h exp=%h", name, ovf_count, exp_cnt); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_grant;
        logic [31:0] exp_sum;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h1000 * (i + 1), i + 1);
        @(negedge clk);
        req_valid  = 4'b1111;
        resp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            exp_grant = 4'b0001 << (n % NUM_REQ);
            exp_sum   = 32'h1000 * ((n % NUM_REQ) + 1) + (n % NUM_REQ) + 1;
            #1;
            n_cmp++; if (req_ready !== exp_grant) begin n_err++; $display("FAIL rr_grant%0d got=%b exp=%b", n, req_ready, exp_grant); end
            @(negedge clk);
            n_cmp++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL rr_exec%0d got ready=%b busy=%b exp 0000 1", n, req_ready, busy); end
            @(negedge clk);
            n_cmp++; if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin n_err++; $display("FAIL rr_resp%0d got ready=%b valid=%b exp 0000 1", n, req_ready, resp_valid); end
            n_cmp++; if (resp_id !== 2'(n % NUM_REQ) || resp_sum !== exp_sum) begin n_err++; $display("FAIL rr_result%0d got id=%0d sum=%h exp id=%0d sum=%h", n, resp_id, resp_sum, n % NUM_REQ, exp_sum); end
            if (n == 4) req_valid = '0;
            @(negedge clk);
        end
        n_cmp++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin n_err++; $display("FAIL rr_drain got busy=%b valid=%b exp 0 0", busy, resp_valid); end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_req(2, 32'd5, 32'd7);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant got=%b exp=0100", req_ready); end
        @(negedge clk);
        set_req(1, 32'd1, 32'd2);
        req_valid = 4'b0010;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (resp_valid !== 1'b1 || resp_sum !== 32'd12 || resp_id !== 2'd2 || resp_cout !== 1'b0 || resp_ovf !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d got v=%b sum=%h id=%0d c=%b o=%b exp 1 0000000c 2 0 0", c, resp_valid, resp_sum, resp_id, resp_cout, resp_ovf); end
            n_cmp++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d got ready=%b busy=%b exp 0000 1", c, req_ready, busy); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_release got valid=%b busy=%b ready=%b exp 0 0 0010", resp_valid, busy, req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b1 || resp_sum !== 32'd3 || resp_id !== 2'd1) begin n_err++; $display("FAIL bp_next got v=%b sum=%h id=%0d exp 1 00000003 1", resp_valid, resp_sum, resp_id); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.ovf_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.ovf_count_q;
        #1;
        n_cmp++; if (ovf_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_preload got=%h exp=ffff", ovf_count); end
        test_single_op("sat", 3, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 16'hFFFF);
    endtask

    task automatic test_reset_mid_op();
        @(negedge clk);
        set_req(3, 32'h7FFFFFFF, 32'h7FFFFFFF);
        req_valid  = 4'b1000;
        resp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rst_grant got=%b exp=1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_exec got busy=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || resp_valid !== 1'b0 || ovf_count !== 16'd0) begin n_err++; $display("FAIL rst_clear got busy=%b valid=%b cnt=%h exp 0 0 0000", busy, resp_valid, ovf_count); end
        n_cmp++; if ({resp_id, resp_sum, resp_cout, resp_ovf} !== 36'd0) begin n_err++; $display("FAIL rst_resp got id=%0d sum=%h c=%b o=%b exp all 0", resp_id, resp_sum, resp_cout, resp_ovf); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_quiet%0d got valid=%b busy=%b exp 0 0", c, resp_valid, busy); end
        end
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rst_restart got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_op("pos_ovf", 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 16'd1);
        test_single_op("neg_ovf", 1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 16'd2);
        test_single_op("mix_a", 2, 32'd100, 32'hFFFFFFA6, 32'd10, 1'b1, 1'b0, 16'd2);
        test_single_op("mix_b", 3, 32'd3456, 32'hFFFFDF65, 32'hFFFFECE5, 1'b0, 1'b0, 16'd2);
        test_single_op("mix_c", 0, 32'd10, 32'hFFFFFFF6, 32'd0, 1'b1, 1'b0, 16'd2);
        apply_reset();
        test_round_robin();
        test_backpressure();
        test_saturation();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
